// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: access direction and response status.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ  = 2'b00,
        RGGEN_WRITE = 2'b01
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Register-bus connection between an rggen master and a responder.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    rggen_direction           direction;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   write_strobe;
    logic                     done;
    logic [BUS_WIDTH-1:0]     read_data;
    rggen_status              status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );
endinterface

// File: rtl/rggen_bus_sram_responder.sv
// Terminates an rggen_bus_if and serves each request from a single-port
// synchronous SRAM with fixed read latency; out-of-range words get an error.
module rggen_bus_sram_responder
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WORDS         = 256,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_WAIT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rggen_bus_if.slave               bus_if,
    output logic                     sram_cs,
    output logic                     sram_we,
    output logic [$clog2(WORDS)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_wdata,
    output logic [DATA_WIDTH/8-1:0]  sram_wmask,
    input  logic [DATA_WIDTH-1:0]    sram_rdata
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_BITS = $clog2(STRB_W);
    localparam int unsigned SRAM_AW   = $clog2(WORDS);
    localparam int unsigned CNT_W     = $clog2(5);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESPOND
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    is_read_q, is_read_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    rggen_status             status_q, status_d;
    logic                    sram_cs_d;
    logic                    sram_we_d;
    logic [SRAM_AW-1:0]      sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_wdata_d;
    logic [STRB_W-1:0]       sram_wmask_d;

    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     in_range;
    logic                     is_write;
    logic                     no_strobe;

    // Request decode; the byte offset within a word is ignored.
    assign word_idx  = bus_if.address >> BYTE_BITS;
    assign in_range  = 64'(word_idx) < 64'(WORDS);
    assign is_write  = bus_if.direction == RGGEN_WRITE;
    assign no_strobe = bus_if.write_strobe == '0;

    assign bus_if.done      = done_q;
    assign bus_if.read_data = read_data_q;
    assign bus_if.status    = status_q;

    // Next-state and next-output logic; outputs are registered one cycle later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_read_d    = is_read_q;
        done_d       = 1'b0;
        read_data_d  = read_data_q;
        status_d     = status_q;
        sram_cs_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        sram_wmask_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.request) begin
                    if (!in_range) begin
                        state_d     = ST_RESPOND;
                        done_d      = 1'b1;
                        status_d    = RGGEN_SLAVE_ERROR;
                        read_data_d = '0;
                    end else if (is_write && no_strobe) begin
                        state_d     = ST_RESPOND;
                        done_d      = 1'b1;
                        status_d    = RGGEN_OKAY;
                        read_data_d = '0;
                    end else begin
                        state_d      = ST_ACCESS;
                        is_read_d    = !is_write;
                        sram_cs_d    = 1'b1;
                        sram_we_d    = is_write;
                        sram_addr_d  = SRAM_AW'(word_idx);
                        sram_wdata_d = bus_if.write_data;
                        sram_wmask_d = bus_if.write_strobe;
                    end
                end
            end
            ST_ACCESS: begin
                if (is_read_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY);
                end else if (WRITE_WAIT == 0) begin
                    state_d     = ST_RESPOND;
                    done_d      = 1'b1;
                    status_d    = RGGEN_OKAY;
                    read_data_d = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WRITE_WAIT);
                end
            end
            ST_WAIT: begin
                // The last count cycle is the one where sram_rdata is valid.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    state_d     = ST_RESPOND;
                    done_d      = 1'b1;
                    status_d    = RGGEN_OKAY;
                    read_data_d = is_read_q ? sram_rdata : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
            status_q    <= RGGEN_OKAY;
            sram_cs     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            sram_wmask  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
            status_q    <= status_d;
            sram_cs     <= sram_cs_d;
            sram_we     <= sram_we_d;
            sram_addr   <= sram_addr_d;
            sram_wdata  <= sram_wdata_d;
            sram_wmask  <= sram_wmask_d;
        end
    end

endmodule
